ssi_quad_rx: RTL and testbench

Four-lane synchronous serial (SSI) receiver. It is the receiving end of the `ssi0_clk` / `ssi0_fss` / `ssi0_xdat[3:0]` link that the sig_acq top level drives toward the ARM. The block oversamples the link in the 110.592 MHz system clock domain and deserialises one word per lane per frame. It is used for FPGA-side loopback checking of the acquisition stream and for any board where the FPGA is the SSI sink.

---
 rtl/ssi_quad_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_ssi_quad_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssi_quad_rx.sv
// Four-lane SSI receiver: oversamples ssi_clk/ssi_fss/ssi_xdat in the clk domain
// and deserialises one WORD_W-bit word per lane per frame, MSB first.
module ssi_quad_rx #(
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ssi_clk,
  input  logic                  ssi_fss,
  input  logic [3:0]            ssi_xdat,
  output logic [4*WORD_W-1:0]   dout,
  output logic                  word_valid,
  output logic                  frame_err,
  output logic [15:0]           word_cnt,
  output logic                  busy
);

  localparam int                CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [SYNC_STAGES-1:0]          clk_sync_q;
  logic [SYNC_STAGES-1:0]          fss_sync_q;
  logic [SYNC_STAGES-1:0][3:0]     dat_sync_q;
  logic                            clk_prev_q;

  logic                            clk_s;
  logic                            fss_s;
  logic [3:0]                      dat_s;
  logic                            re_s;

  logic                            start_s;
  logic                            shift_s;
  logic                            done_s;
  logic                            err_s;

  logic [3:0][WORD_W-1:0]          shreg_q, shreg_d;
  logic [CNT_W-1:0]                bit_cnt_q, bit_cnt_d;
  logic [15:0]                     timer_q, timer_d;
  logic [4*WORD_W-1:0]             dout_q, dout_d;
  logic                            valid_q, valid_d;
  logic                            ferr_q, ferr_d;
  logic [15:0]                     word_cnt_q, word_cnt_d;

  // Link synchronisers plus one extra ssi_clk stage for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '0;
      fss_sync_q <= '0;
      dat_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ssi_clk};
      fss_sync_q <= {fss_sync_q[SYNC_STAGES-2:0], ssi_fss};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ssi_xdat};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign fss_s = fss_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign re_s  = clk_s & ~clk_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (re_s && fss_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (re_s) begin
          if (!fss_s && (bit_cnt_q == LAST_BIT)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (timer_q == TMO_LAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A sync seen mid-word restarts the word on this bit and flags the fault
  always_comb begin
    start_s = 1'b0;
    shift_s = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_s = re_s & fss_s;
      end
      ST_SHIFT: begin
        if (re_s) begin
          if (fss_s) begin
            start_s = 1'b1;
            err_s   = 1'b1;
          end else begin
            shift_s = 1'b1;
            done_s  = (bit_cnt_q == LAST_BIT);
          end
        end else begin
          err_s = (timer_q == TMO_LAST);
        end
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = 16'h0000;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    ferr_d     = err_s;
    word_cnt_d = word_cnt_q + 16'h0001;

    for (int l = 0; l < 4; l++) begin
      if (start_s) begin
        shreg_d[l] = {{(WORD_W-1){1'b0}}, dat_s[l]};
      end else if (shift_s) begin
        shreg_d[l] = {shreg_q[l][WORD_W-2:0], dat_s[l]};
      end else begin
        shreg_d[l] = shreg_q[l];
      end
    end

    if (start_s) begin
      bit_cnt_d = CNT_ONE;
    end else if (shift_s) begin
      bit_cnt_d = bit_cnt_q + CNT_ONE;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    if (done_s || (state_d == ST_IDLE)) begin
      bit_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_cnt_d;
    end

    if ((state_q == ST_SHIFT) && (state_d == ST_SHIFT) && !re_s) begin
      timer_d = timer_q + 16'h0001;
    end else begin
      timer_d = 16'h0000;
    end

    if (done_s) begin
      dout_d  = shreg_d;
      valid_d = 1'b1;
    end else begin
      dout_d  = dout_q;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      timer_q   <= 16'h0000;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Good-frame counter advances only on completed words and wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= 16'h0000;
    end else if (done_s) begin
      word_cnt_q <= word_cnt_d;
    end else begin
      word_cnt_q <= word_cnt_q;
    end
  end

  assign dout       = dout_q;
  assign word_valid = valid_q;
  assign frame_err  = ferr_q;
  assign word_cnt   = word_cnt_q;
  assign busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_ssi_quad_rx.sv
// Self-checking bench for ssi_quad_rx: table-driven frames, hand-written corner
// sequences and randomized frames against a frame-level scoreboard.
module tb_ssi_quad_rx;

  localparam int W    = 16;
  localparam int SYNC = 2;
  localparam int TMO  = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ssi_clk = 1'b0;
  logic          ssi_fss = 1'b0;
  logic [3:0]    ssi_xdat = 4'h0;
  logic [63:0]   dout;
  logic          word_valid;
  logic          frame_err;
  logic [15:0]   word_cnt;
  logic          busy;

  ssi_quad_rx #(.WORD_W(W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ssi_clk    (ssi_clk),
    .ssi_fss    (ssi_fss),
    .ssi_xdat   (ssi_xdat),
    .dout       (dout),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .word_cnt   (word_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] lanes;
    int               half;
    logic [63:0]      exp_dout;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          valid_seen = 0;
  int          err_seen = 0;
  logic [15:0] model_cnt = 16'h0000;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame-level scoreboard: every word_valid must match the next expected frame
  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid) begin
        valid_seen++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got dout %0h expected no word", dout);
        end else begin
          mon_exp = exp_q.pop_front();
          model_cnt = model_cnt + 16'h0001;
          if (dout !== mon_exp || word_cnt !== model_cnt) begin
            miscompares++;
            $display("FAIL word: got dout %0h cnt %0h expected dout %0h cnt %0h",
                     dout, word_cnt, mon_exp, model_cnt);
          end
        end
      end
      if (frame_err) err_seen++;
    end
  end

  task automatic send_bit(input logic f, input logic [3:0] d, input int half);
    ssi_clk  = 1'b0;
    ssi_fss  = f;
    ssi_xdat = d;
    repeat (half) @(negedge clk);
    ssi_clk = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0][15:0] w, input int half);
    for (int b = 15; b >= 0; b--)
      send_bit(b == 15, {w[3][b], w[2][b], w[1][b], w[0][b]}, half);
  endtask

  function automatic logic [63:0] pack(input logic [3:0][15:0] w);
    return {w[3], w[2], w[1], w[0]};
  endfunction

  vec_t             tbl[4];
  logic [3:0][15:0] fw;
  logic [63:0]      prev_dout;
  int               v0, e0, n;
  logic             busy_mid;
  logic             noisy;

  initial begin
    tbl[0].lanes = {16'hFFFF, 16'h0F0F, 16'hABCD, 16'h1234}; tbl[0].half = 4;
    tbl[0].exp_dout = 64'hFFFF_0F0F_ABCD_1234;
    tbl[1].lanes = {16'h0000, 16'h0000, 16'h0000, 16'h0000}; tbl[1].half = 3;
    tbl[1].exp_dout = 64'h0000_0000_0000_0000;
    tbl[2].lanes = {16'h1008, 16'h2004, 16'h4002, 16'h8001}; tbl[2].half = 3;
    tbl[2].exp_dout = 64'h1008_2004_4002_8001;
    tbl[3].lanes = {16'hC3A5, 16'h7E81, 16'h0001, 16'h8000}; tbl[3].half = 6;
    tbl[3].exp_dout = 64'hC3A5_7E81_0001_8000;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    chk("rst_dout", dout, 64'h0);
    chk("rst_word_valid", {63'h0, word_valid}, 64'h0);
    chk("rst_frame_err", {63'h0, frame_err}, 64'h0);
    chk("rst_word_cnt", {48'h0, word_cnt}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);

    noisy = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (dout != 64'h0 || word_valid || frame_err || word_cnt != 16'h0 || busy) noisy = 1'b1;
    end
    chk("idle_quiet", {63'h0, noisy}, 64'h0);

    for (int i = 0; i < 4; i++) begin
      v0 = valid_seen;
      exp_q.push_back(tbl[i].exp_dout);
      send_frame(tbl[i].lanes, tbl[i].half);
      repeat (8) @(negedge clk);
      chk("tbl_valid", 64'(valid_seen), 64'(v0 + 1));
      chk("tbl_dout", dout, tbl[i].exp_dout);
      chk("tbl_cnt", {48'h0, word_cnt}, 64'(i + 1));
    end
    chk("tbl_no_err", 64'(err_seen), 64'h0);

    v0 = valid_seen;
    for (int i = 1; i <= 3; i++) begin
      fw = {16'h0000, 16'h0000, 16'h0000, 16'(i)};
      exp_q.push_back(pack(fw));
      send_frame(fw, 3);
    end
    repeat (8) @(negedge clk);
    chk("b2b_valid", 64'(valid_seen), 64'(v0 + 3));
    chk("b2b_cnt", {48'h0, word_cnt}, 64'd7);

    v0 = valid_seen;
    e0 = err_seen;
    for (int b = 0; b < 8; b++) send_bit(b == 0, 4'(b + 5), 4);
    fw = {16'h3C3C, 16'h5A5A, 16'h1111, 16'hE00F};
    exp_q.push_back(pack(fw));
    send_frame(fw, 4);
    repeat (8) @(negedge clk);
    chk("premature_err", 64'(err_seen), 64'(e0 + 1));
    chk("premature_valid", 64'(valid_seen), 64'(v0 + 1));
    chk("premature_lane2", {48'h0, dout[47:32]}, 64'h5A5A);
    prev_dout = pack(fw);

    e0 = err_seen;
    for (int b = 0; b < 6; b++) send_bit(b == 0, 4'hA, 4);
    ssi_clk = 1'b0;
    ssi_fss = 1'b0;
    repeat (4) @(negedge clk);
    ssi_clk = 1'b1;
    n = 0;
    busy_mid = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (n == 10) busy_mid = busy;
      if (frame_err) break;
    end
    chk("stall_busy_mid", {63'h0, busy_mid}, 64'h1);
    chk("stall_latency", 64'(n), 64'(SYNC + TMO + 1));
    @(negedge clk);
    chk("stall_busy", {63'h0, busy}, 64'h0);
    chk("stall_dout_held", dout, prev_dout);
    chk("stall_err", 64'(err_seen), 64'(e0 + 1));
    fw = {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    exp_q.push_back(pack(fw));
    send_frame(fw, 3);
    repeat (8) @(negedge clk);
    chk("stall_recover", dout, 64'h0123_4567_89AB_CDEF);

    v0 = valid_seen;
    e0 = err_seen;
    for (int b = 0; b < 5; b++) send_bit(b == 0, 4'hF, 3);
    rst = 1'b1;
    ssi_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_cnt = 16'h0000;
    repeat (10) @(negedge clk);
    chk("rstmid_strobes", 64'(valid_seen + err_seen), 64'(v0 + e0));
    chk("rstmid_cnt", {48'h0, word_cnt}, 64'h0);
    fw = {16'hBEEF, 16'hCAFE, 16'hF00D, 16'h0BAD};
    exp_q.push_back(pack(fw));
    send_frame(fw, 5);
    repeat (8) @(negedge clk);
    chk("rstmid_next", dout, 64'hBEEF_CAFE_F00D_0BAD);
    chk("rstmid_next_cnt", {48'h0, word_cnt}, 64'h1);

    @(negedge clk);
    force dut.word_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.word_cnt_q;
    model_cnt = 16'hFFFF;
    @(negedge clk);
    chk("wrap_forced", {48'h0, word_cnt}, 64'hFFFF);
    fw = {16'h7777, 16'h0000, 16'hFFFF, 16'h2468};
    exp_q.push_back(pack(fw));
    send_frame(fw, 3);
    repeat (8) @(negedge clk);
    chk("wrap_cnt", {48'h0, word_cnt}, 64'h0);

    e0 = err_seen;
    for (int i = 0; i < 20; i++) begin
      int half;
      int gap;
      half = int'($urandom_range(6, 3));
      gap  = int'($urandom_range(2, 0));
      for (int g = 0; g < gap; g++) send_bit(1'b0, 4'($urandom), half);
      fw = {$urandom(), $urandom()};
      exp_q.push_back(pack(fw));
      send_frame(fw, half);
    end
    repeat (10) @(negedge clk);
    chk("rand_drained", 64'(exp_q.size()), 64'h0);
    chk("rand_no_err", 64'(err_seen), 64'(e0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
